// File: rtl/dsp_result_capture.sv
// dsp_result_capture: aligns the DUT strobe to the DSP pipeline latency,
// folds each captured 108-bit result into a MISR and a saturating counter,
// buffers results in a FIFO and streams them out as framed bytes.
module dsp_result_capture #(
  parameter int          LATENCY  = 1,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] SIG_POLY = 32'h04C11DB7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         strobe,
  input  logic [107:0] z,
  input  logic         clear,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  signature,
  output logic [15:0]  sample_count,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_t;

  // XOR-compress a result into one 32-bit word.
  function automatic logic [31:0] fold(input logic [107:0] v);
    return v[31:0] ^ v[63:32] ^ v[95:64] ^ {20'h0, v[107:96]};
  endfunction

  // One MISR step: shift with polynomial feedback, then mix in the folded result.
  function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic [107:0] v);
    return ({sig[30:0], 1'b0} ^ (sig[31] ? SIG_POLY : 32'h0)) ^ fold(v);
  endfunction

  // Little-endian byte i of the result zero-extended to 112 bits.
  function automatic logic [7:0] byte_sel(input logic [107:0] v, input logic [3:0] i);
    logic [111:0] w;
    w = {4'h0, v};
    return w[{i, 3'b000} +: 8];
  endfunction

  logic cap_en_s;

  generate
    if (LATENCY == 0) begin : g_nodly
      assign cap_en_s = strobe;
    end else begin : g_dly
      logic [LATENCY-1:0] dly_r;
      // Strobe delay line matching the DSP pipeline latency.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dly_r <= {LATENCY{1'b0}};
        end else begin
          for (int i = LATENCY - 1; i > 0; i--) begin
            dly_r[i] <= dly_r[i-1];
          end
          dly_r[0] <= strobe;
        end
      end
      assign cap_en_s = dly_r[LATENCY-1];
    end
  endgenerate

  // FIFO storage and bookkeeping
  logic [107:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_s, empty_s, push_s, pop_s, xfer_s;
  logic [107:0]  head_s;

  // Serializer state
  state_t      state_r, state_nx;
  logic [3:0]  idx_r, idx_nx;
  logic [7:0]  out_data_r, data_nx;
  logic        out_valid_r, valid_nx;

  // Statistics
  logic [31:0] sig_r;
  logic [15:0] cnt_r;
  logic        ovf_r;

  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == {(AW+1){1'b0}});
  assign head_s  = mem_r[rd_ptr_r];
  assign xfer_s  = out_valid_r && out_ready;
  // The last data byte leaving frees the head entry; a full FIFO can then accept in the same edge.
  assign pop_s   = (state_r == DATA) && xfer_s && (idx_r == 4'd13);
  assign push_s  = cap_en_s && (!full_s || pop_s);

  // FIFO payload write (no reset needed: validity tracked by count/pointers).
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= z;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Signature, saturating sample counter and sticky overflow; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_r <= 32'hFFFF_FFFF;
      cnt_r <= 16'd0;
      ovf_r <= 1'b0;
    end else if (clear) begin
      sig_r <= 32'hFFFF_FFFF;
      cnt_r <= 16'd0;
      ovf_r <= 1'b0;
    end else begin
      if (cap_en_s) begin
        sig_r <= misr_next(sig_r, z);
        if (cnt_r != 16'hFFFF) cnt_r <= cnt_r + 16'd1;
        else                   cnt_r <= cnt_r;
      end else begin
        sig_r <= sig_r;
        cnt_r <= cnt_r;
      end
      if (cap_en_s && full_s && !pop_s) ovf_r <= 1'b1;
      else                              ovf_r <= ovf_r;
    end
  end

  // Serializer next state, byte index and the registered output values they imply.
  always_comb begin
    state_nx = state_r;
    idx_nx   = idx_r;
    valid_nx = 1'b0;
    data_nx  = 8'h00;
    case (state_r)
      IDLE: begin
        if (!empty_s) state_nx = HDR;
        else          state_nx = IDLE;
      end
      HDR: begin
        if (xfer_s) begin
          state_nx = DATA;
          idx_nx   = 4'd0;
        end else begin
          state_nx = HDR;
        end
      end
      DATA: begin
        if (xfer_s) begin
          if (idx_r == 4'd13) begin
            state_nx = IDLE;
            idx_nx   = 4'd0;
          end else begin
            idx_nx = idx_r + 4'd1;
          end
        end else begin
          idx_nx = idx_r;
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 4'd0;
      end
    endcase
    case (state_nx)
      HDR: begin
        valid_nx = 1'b1;
        data_nx  = 8'hA5;
      end
      DATA: begin
        valid_nx = 1'b1;
        data_nx  = byte_sel(head_s, idx_nx);
      end
      default: begin
        valid_nx = 1'b0;
        data_nx  = 8'h00;
      end
    endcase
  end

  // Serializer state and registered byte-stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= 4'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
    end else begin
      state_r     <= state_nx;
      idx_r       <= idx_nx;
      out_valid_r <= valid_nx;
      out_data_r  <= data_nx;
    end
  end

  assign out_data     = out_data_r;
  assign out_valid    = out_valid_r;
  assign signature    = sig_r;
  assign sample_count = cnt_r;
  assign overflow     = ovf_r;

endmodule

// File: doc/dsp_result_capture.md
# dsp_result_capture

Downstream result stage for the Nexus DSP hardware-test DUTs. It aligns the DUT's `strobe` with the DSP primitive's pipeline latency and captures each valid 108-bit `z` result. Every captured result is folded into a 32-bit MISR signature and counter. Results are also buffered in a small FIFO and streamed to the host link as framed bytes over a valid/ready interface.

## Interface
- `LATENCY`, default 1: cycles from `strobe` to a valid `z`; legal range 0..8. 1 matches a pipeline-register-only configuration.
- `DEPTH`, default 4: FIFO entries, each 108 bits wide; power of two, 2..16.
- `SIG_POLY`, default 32'h04C11DB7: MISR feedback polynomial.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `strobe` in 1: same strobe that drives the DUT's clock enables and resets.
- `z` in 108: DUT result.
- `clear` in 1: synchronous clear of the statistics.
- `out_data` out 8: serial byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: sink accepts the byte.
- `signature` out 32: MISR state.
- `sample_count` out 16: number of captured samples; saturates.
- `overflow` out 1: sticky; a sample was dropped because the FIFO was full.

## Operation
- **Delay line.** `strobe` passes through `LATENCY` register stages to produce `cap_en`. With `LATENCY`=0, `cap_en` = `strobe`. The delay line is not affected by `clear`.
- **Capture.** On a rising edge with `cap_en`=1, the block samples `z` and performs three actions:
  - MISR update.
  - Counter increment.
  - FIFO push.
- **Fold function.** fold(z) = z[31:0] ^ z[63:32] ^ z[95:64] ^ {20'b0, z[107:96]}.
- **MISR update.** sig ← ({sig[30:0],1'b0} ^ (sig[31] ? `SIG_POLY` : 0)) ^ fold(z).
- **Counter.** `sample_count` increments and holds at 16'hFFFF.
- **FIFO push.**
  - If the FIFO is not full, `z` is pushed.
  - If the FIFO is full and no pop occurs in the same cycle, the sample is dropped and `overflow` is set. The signature and counter still update.
  - Push and pop in the same cycle while full: both happen, and no overflow is flagged.
- **Clear.**
  - `clear`=1 sets `signature` to 32'hFFFFFFFF, `sample_count` to 0 and `overflow` to 0.
  - If `cap_en` is high in the same cycle, `clear` wins for all three; the sample is still pushed to the FIFO if there is room.
  - The FIFO and serializer are unaffected by `clear`.
- **Serializer FSM.** States are IDLE, HDR and DATA, with byte index `idx` in 0..13.
  - IDLE: when the FIFO is non-empty, go to HDR. `out_valid` stays 0 in IDLE.
  - HDR: `out_data`=8'hA5, `out_valid`=1. On `out_valid`&&`out_ready`, go to DATA with `idx`=0.
  - DATA: `out_data` = byte `idx` of {4'b0, head}, little-endian, so byte 0 = head[7:0] and byte 13 = {4'b0, head[107:104]}.
    - Each transfer increments `idx`.
    - On the transfer of byte 13, pop the FIFO and return to IDLE.
  - A frame is 15 bytes: the header followed by 14 data bytes.
- **Handshake.** While `out_valid`=1 and `out_ready`=0, `out_data` is held stable. `out_valid` never deasserts before its transfer completes.
- **Reset.** All registers clear:
  - `out_valid`=0, `out_data`=0.
  - `signature`=32'hFFFFFFFF, `sample_count`=0, `overflow`=0.
  - FIFO empty, delay line 0, FSM in IDLE.
  - Reset applied mid-frame abandons the frame; bytes not yet sent are lost.

## Timing
- A sample captured at edge k is visible in `signature` and `sample_count` after edge k.
- A push at edge k into an empty FIFO while the FSM is in IDLE:
  - FSM enters HDR at edge k+1, so `out_valid` is high during cycle k+1.
  - With `out_ready` held at 1, the header transfers at edge k+2, byte 0 at edge k+3, and so on at one byte per cycle.
- After the last byte transfers, there is one IDLE bubble cycle before the next header.
- Sustained throughput is 16 cycles per sample. Strobes arriving faster than that eventually cause overflow.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset values.** Assert `rst` asynchronously mid-cycle → all outputs are at their reset values immediately: `signature`=FFFFFFFF, `out_valid`=0.
- **Single zero sample.** `LATENCY`=1, one `strobe` pulse with `z`=0 one cycle later → `signature`=32'hFB3EE249, `sample_count`=1, then a 15-byte frame A5 followed by 14×00.
- **Byte order.** `z`={4'hF, 104'h0102030405060708090A0B0C0D}, `out_ready`=1 → bytes A5,0D,0C,0B,0A,09,08,07,06,05,04,03,02,01,0F, then `out_valid`=0.
- **Back-pressure.** Toggle `out_ready` randomly during a frame → identical byte sequence, and `out_data` holds steady whenever `out_valid`=1 and `out_ready`=0.
- **Overflow.** `DEPTH`=4, `out_ready`=0, 6 strobes → `sample_count`=6, `overflow`=1, and after releasing `out_ready` exactly 4 frames are sent.
- **Clear.** `clear` coincident with `cap_en` → `signature`=FFFFFFFF, `sample_count`=0, `overflow`=0, and the sample still appears as a frame.
